// File: rtl/hex_scan_ctrl.sv
// Time-multiplexes one external 7-segment decoder across HEX0..HEX7 with an
// 8-entry digit register file. Define HEX_LEAD_ZERO_BLANK_EN for leading-zero blanking.
module hex_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DIV_W    = 16
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_en_digit,
  output logic [3:0] dec_bcd,
  input  logic [0:6] dec_seg,
  output logic [0:6] HEX0,
  output logic [0:6] HEX1,
  output logic [0:6] HEX2,
  output logic [0:6] HEX3,
  output logic [0:6] HEX4,
  output logic [0:6] HEX5,
  output logic [0:6] HEX6,
  output logic [0:6] HEX7,
  output logic       frame_done
);

  localparam int unsigned NSLOT = 8;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CAPTURE} state_t;

  state_t             state, state_next;
  logic [DIV_W-1:0]   count;
  logic               tick;
  logic [2:0]         slot;
  logic [3:0]         value [NSLOT];
  logic [NSLOT-1:0]   en;
  logic [0:6]         hex_q [NSLOT];

  logic               load_bcd;
  logic               capture;
  logic               ready_next;
  logic [0:6]         seg_next;
  logic               wr_accept;

  assign tick      = (count == DIV_LAST);
  assign wr_accept = wr_valid && wr_ready;

`ifdef HEX_LEAD_ZERO_BLANK_EN
  // Slot k blanks when it is zero and every higher slot is blank-eligible.
  logic [NSLOT-1:0] elig;
  logic [NSLOT-1:0] hi_mask;
  logic             lz_blank;

  always_comb begin
    elig = '0;
    for (int i = 0; i < int'(NSLOT); i++) begin
      elig[i] = !en[i] || (value[i] == 4'd0);
    end
    hi_mask  = 8'hFE << slot;
    lz_blank = (slot != 3'd0) && (value[slot] == 4'd0) && ((elig & hi_mask) == hi_mask);
  end
`endif

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state logic; ticks outside IDLE are simply ignored.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (tick) state_next = S_DRIVE;
      S_DRIVE:   state_next = S_CAPTURE;
      S_CAPTURE: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Output/datapath control decode.
  always_comb begin
    load_bcd   = 1'b0;
    capture    = 1'b0;
    ready_next = (state_next == S_IDLE);
    seg_next   = dec_seg;
    case (state)
      S_IDLE:    load_bcd = tick;
      S_CAPTURE: begin
        capture = 1'b1;
`ifdef HEX_LEAD_ZERO_BLANK_EN
        if (!en[slot] || lz_blank) seg_next = SEG_BLANK;
`else
        if (!en[slot]) seg_next = SEG_BLANK;
`endif
      end
      default: ;
    endcase
  end

  // Prescaler, register file, decoder drive and HEX capture.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      count      <= '0;
      slot       <= '0;
      en         <= '0;
      dec_bcd    <= '0;
      frame_done <= 1'b0;
      wr_ready   <= 1'b1;
      for (int i = 0; i < int'(NSLOT); i++) begin
        value[i] <= '0;
        hex_q[i] <= SEG_BLANK;
      end
    end else begin
      count      <= tick ? '0 : count + DIV_W'(1);
      wr_ready   <= ready_next;
      frame_done <= capture && (slot == 3'd7);
      if (wr_accept) begin
        value[wr_addr] <= wr_data;
        en[wr_addr]    <= wr_en_digit;
      end
      if (load_bcd) dec_bcd <= value[slot];
      if (capture) begin
        hex_q[slot] <= seg_next;
        slot        <= slot + 3'd1;
      end
    end
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];
  assign HEX6 = hex_q[6];
  assign HEX7 = hex_q[7];

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Directed bench for hex_scan_ctrl with SCAN_DIV = 4 and a table-driven
// write/frame check plus hand-written handshake, blanking and reset sequences.
module tb_hex_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_en_digit;
  logic [3:0] dec_bcd;
  logic [0:6] dec_seg;
  logic [0:6] hex [8];
  logic       frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [0:6] BL = 7'b1111111;

  always #5 clk = ~clk;

  hex_scan_ctrl #(.SCAN_DIV(4), .DIV_W(16)) dut (
    .CLOCK_50(clk), .RESET_N(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_en_digit(wr_en_digit),
    .dec_bcd(dec_bcd), .dec_seg(dec_seg),
    .HEX0(hex[0]), .HEX1(hex[1]), .HEX2(hex[2]), .HEX3(hex[3]),
    .HEX4(hex[4]), .HEX5(hex[5]), .HEX6(hex[6]), .HEX7(hex[7]),
    .frame_done(frame_done)
  );

  // Shared decoder model: active-low, a..g from MSB of literal, blank above 9.
  always_comb begin
    case (dec_bcd)
      4'd0: dec_seg = 7'b0000001;
      4'd1: dec_seg = 7'b1001111;
      4'd2: dec_seg = 7'b0010010;
      4'd3: dec_seg = 7'b0000110;
      4'd4: dec_seg = 7'b1001100;
      4'd5: dec_seg = 7'b0100100;
      4'd6: dec_seg = 7'b0100000;
      4'd7: dec_seg = 7'b0001111;
      4'd8: dec_seg = 7'b0000000;
      4'd9: dec_seg = 7'b0000100;
      default: dec_seg = 7'b1111111;
    endcase
  end

  typedef struct {
    int         grp;
    logic [2:0] slot;
    logic [3:0] val;
    logic       en;
    logic [0:6] exp;
  } vec_t;

  vec_t       vecs [10];
  logic [0:6] exp_hex [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all_hex(input string nm);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_hex%0d", nm, i), 32'(hex[i]), 32'(exp_hex[i]));
  endtask

  task automatic chk_reset_state(input string nm);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_hex%0d", nm, i), 32'(hex[i]), 32'(BL));
    chk({nm, "_ready"}, 32'(wr_ready), 32'd1);
    chk({nm, "_frame"}, 32'(frame_done), 32'd0);
    chk({nm, "_bcd"}, 32'(dec_bcd), 32'd0);
  endtask

  // Write through the handshake; called at a negedge, returns at a negedge.
  task automatic do_write(input logic [2:0] a, input logic [3:0] d, input logic e);
    bit acc = 0;
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_en_digit = e;
    for (int n = 0; n < 20 && !acc; n++) begin
      if (wr_ready) acc = 1;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    if (!acc) chk("write_timeout", 32'd0, 32'd1);
  endtask

  // Wait for a frame_done pulse and confirm it lasts exactly one cycle.
  task automatic wait_frame();
    int n = 0;
    while (!frame_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("frame_seen", 32'(frame_done), 32'd1);
    @(negedge clk);
    chk("frame_pulse_width", 32'(frame_done), 32'd0);
  endtask

  // Wait at negedges for wr_ready to reach the requested level.
  task automatic wait_ready(input logic lvl);
    int n = 0;
    while (wr_ready !== lvl && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(wr_ready), 32'(lvl));
  endtask

  // Release reset with slot 0 = 5 written on the first active edge, then
  // check HEX0 updates exactly two cycles after the first tick.
  task automatic release_and_write5(input string nm);
    rst_n = 1'b1; wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 4'd5; wr_en_digit = 1'b1;
    @(negedge clk);                       // after E1: write taken
    wr_valid = 1'b0;
    repeat (3) @(negedge clk);            // after E4: tick edge, DRIVE
    chk({nm, "_drive_bcd"}, 32'(dec_bcd), 32'd5);
    chk({nm, "_drive_ready"}, 32'(wr_ready), 32'd0);
    @(negedge clk);                       // after E5: CAPTURE, not yet latched
    chk({nm, "_hex0_early"}, 32'(hex[0]), 32'(BL));
    @(negedge clk);                       // after E6: latched
    chk({nm, "_hex0"}, 32'(hex[0]), 32'(7'b0100100));
    chk({nm, "_ready_back"}, 32'(wr_ready), 32'd1);
    for (int i = 1; i < 8; i++) chk($sformatf("%s_hex%0d", nm, i), 32'(hex[i]), 32'(BL));
  endtask

  initial begin
    int stalls;

    vecs[0] = '{0, 3'd0, 4'd0,  1'b1, 7'b0000001};
    vecs[1] = '{0, 3'd1, 4'd1,  1'b1, 7'b1001111};
    vecs[2] = '{0, 3'd2, 4'd2,  1'b1, 7'b0010010};
    vecs[3] = '{0, 3'd3, 4'd3,  1'b1, 7'b0000110};
    vecs[4] = '{0, 3'd4, 4'd4,  1'b1, 7'b1001100};
    vecs[5] = '{0, 3'd5, 4'd5,  1'b1, 7'b0100100};
    vecs[6] = '{0, 3'd6, 4'd6,  1'b1, 7'b0100000};
    vecs[7] = '{0, 3'd7, 4'd7,  1'b1, 7'b0001111};
    vecs[8] = '{1, 3'd2, 4'd9,  1'b0, 7'b1111111};
    vecs[9] = '{1, 3'd3, 4'd12, 1'b1, 7'b1111111};

    rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_en_digit = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");

    release_and_write5("single");
    for (int i = 0; i < 8; i++) exp_hex[i] = BL;
    exp_hex[0] = 7'b0100100;

    // Table-driven groups: write, then check a full frame taken afterwards.
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 10; i++) begin
        if (vecs[i].grp == g) begin
          do_write(vecs[i].slot, vecs[i].val, vecs[i].en);
          exp_hex[vecs[i].slot] = vecs[i].exp;
        end
      end
      wait_frame();
      wait_frame();
      chk_all_hex($sformatf("grp%0d", g));
    end

    // Slot 3 (value 12) DRIVE: frame_done seen after E34-equivalent, slot 3
    // tick is 14 edges later.
    wait_frame();
    repeat (13) @(negedge clk);
    chk("slot3_drive_bcd", 32'(dec_bcd), 32'hC);
    chk("slot3_drive_ready", 32'(wr_ready), 32'd0);

    // Handshake stall: raise wr_valid in DRIVE, expect two stalled cycles.
    wait_ready(1'b1);
    wait_ready(1'b0);
    wr_valid = 1'b1; wr_addr = 3'd6; wr_data = 4'd8; wr_en_digit = 1'b1;
    stalls = 0;
    for (int n = 0; n < 10 && !wr_ready; n++) begin
      stalls++;
      @(negedge clk);
      chk("stall_data_stable", 32'(wr_data), 32'd8);
    end
    chk("stall_cycles", 32'(stalls), 32'd2);
    @(negedge clk);
    wr_valid = 1'b0;
    chk("write_no_direct_hex6", 32'(hex[6]), 32'(exp_hex[6]));
    exp_hex[6] = 7'b0000000;
    wait_frame();
    wait_frame();
    chk_all_hex("stall");

    // Leading-zero pattern: slots 7..0 = 0,0,0,0,0,3,0,0 all enabled.
    for (int i = 0; i < 8; i++) begin
      do_write(3'(i), (i == 2) ? 4'd3 : 4'd0, 1'b1);
      exp_hex[i] = 7'b0000001;
    end
    exp_hex[2] = 7'b0000110;
`ifdef HEX_LEAD_ZERO_BLANK_EN
    for (int i = 3; i < 8; i++) exp_hex[i] = BL;
`endif
    wait_frame();
    wait_frame();
    chk_all_hex("lzb");

    // Reset asserted during DRIVE aborts the scan.
    wait_ready(1'b1);
    wait_ready(1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_state("midreset");
    @(negedge clk);
    chk_reset_state("midreset_hold");
    release_and_write5("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_scan_ctrl.md
Name: hex_scan_ctrl

Overview:
- Scheduler that shares one external combinational 4-bit-to-7-segment decoder across the eight DE2 displays HEX0..HEX7.
- Holds an 8-entry digit register file written through a valid/ready port.
- Scans the slots in round-robin: drives each stored nibble to the shared decoder, then latches the returned active-low segment pattern into that slot's HEX register.
- Sits between user logic (counters, switch readers) and the board displays.

Parameters:
- SCAN_DIV, 50000, clock cycles between slot ticks (1 kHz slot rate at 50 MHz); legal range 3..2^DIV_W.
- DIV_W, 16, width of the prescaler counter.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid and wr_ready are both 1 on a rising edge.
- wr_addr  in  3  target slot (0 = HEX0 ... 7 = HEX7).
- wr_data  in  4  nibble to display.
- wr_en_digit  in  1  1 = slot shown; 0 = slot forced blank.
- dec_bcd  out  4  nibble presented to the shared decoder (registered).
- dec_seg  in  7 [0:6]  decoder result, active-low, bit 0 = segment a.
- HEX0..HEX7  out  7 each [0:6]  registered active-low segment outputs.
- frame_done  out  1  one-cycle pulse after the HEX7 capture.

Behaviour:
- Reset (RESET_N = 0 at an edge) sets:
  - HEX0..HEX7 = 7'b1111111.
  - All digit entries: value 0, enable 0.
  - Prescaler 0, slot 0, state IDLE.
  - dec_bcd = 0, frame_done = 0, wr_ready = 1.
- Reset mid-scan aborts the scan. No partial capture occurs.
- Prescaler:
  - Free-running, counts 0..SCAN_DIV-1, then wraps to 0.
  - tick = 1 in the cycle when the count equals SCAN_DIV-1.
- State machine (3 states):
  - IDLE: wr_ready = 1. On tick: dec_bcd <= value[slot], go to DRIVE.
  - DRIVE: wr_ready = 0. dec_bcd is stable for the shared decoder. Next cycle go to CAPTURE.
  - CAPTURE: wr_ready = 0.
    - HEX[slot] <= dec_seg if enable[slot] = 1, else 7'b1111111.
    - slot <= slot + 1, wrapping 7 -> 0.
    - frame_done <= 1 when slot = 7.
    - Go to IDLE.
- Latency: a slot's HEX output updates 2 cycles after its tick. A full refresh takes 8*SCAN_DIV cycles.
- Ticks cannot fall outside IDLE because SCAN_DIV >= 3. A tick outside IDLE is dropped (defensive rule).
- Writes:
  - Accepted only in IDLE.
  - Take effect on the next edge.
  - Are visible at the next scan of that slot. A write never changes an already-latched HEX value directly.
  - wr_valid held while wr_ready = 0 stalls. Data must stay stable until accepted.
  - A write accepted in the same cycle as a tick is committed, but the DRIVE started on that edge uses the old value for that slot.
- Nibble values 10..15 are stored and passed through unchanged. The segment pattern is whatever the decoder returns (blank from the team decoder).
- dec_bcd holds its last value outside DRIVE.
- frame_done is 0 in every cycle except the one after the slot-7 CAPTURE.

Optional Feature:
- Macro: HEX_LEAD_ZERO_BLANK_EN.
- Defined: leading-zero blanking. In CAPTURE, slot k is blanked when:
  - value[k] = 0, and
  - every slot j > k is blank-eligible (enable 0 or value 0).
  - Slot 0 is never blanked by this rule.
  - The check uses register-file contents in the CAPTURE cycle.
- Undefined: zeros display normally; only enable = 0 blanks a slot.

Test Plan (SCAN_DIV = 4):
- Reset: hold RESET_N = 0 for 3 cycles -> all HEX = 7'b1111111, wr_ready = 1, frame_done = 0, dec_bcd = 0.
- Single write: slot 0 = 5, enable 1; bench decoder returns 7'b0100100 for 5 -> HEX0 = 7'b0100100 two cycles after the first tick; HEX1..HEX7 stay 7'b1111111.
- Full frame: slots 0..7 = 0..7, all enabled -> after 32 cycles all HEX match the decoder table; frame_done pulses once, the cycle after the HEX7 update.
- Handshake stall: assert wr_valid in the tick cycle + 1 (DRIVE) -> wr_ready = 0 for 2 cycles; write accepted on the first IDLE edge; data stable throughout.
- Disable and out-of-range: slot 2 = 9 with enable 0 -> HEX2 = 7'b1111111. Slot 3 = 12 with enable 1 -> dec_bcd = 4'hC during DRIVE and HEX3 = 7'b1111111 from the decoder default.
- Reset mid-operation, plus blanking when HEX_LEAD_ZERO_BLANK_EN is defined: slots 7..0 = 0,0,0,0,0,3,0,0 -> HEX7..HEX3 blank; HEX2 = 3, HEX1 = 0, HEX0 = 0 displayed. Asserting RESET_N = 0 during DRIVE -> all HEX blank and slot = 0 on the next edge.
